mem_port_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency program/data memory between the instruction-fetch

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_pick.sv | 24 ++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the program/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DP = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Two-requester winner select: fixed priority side, overridden when its streak limit is hit.
module arb_pick (
    input  logic req_a,
    input  logic req_b,
    input  logic prio,
    input  logic streak_hit,
    output logic gnt_a,
    output logic gnt_b
);

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (req_a && req_b) begin
            // prio=1 favours b; a hit streak hands the slot to the other side
            if (prio ^ streak_hit) gnt_b = 1'b1;
            else                   gnt_a = 1'b1;
        end else begin
            gnt_a = req_a;
            gnt_b = req_b;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and datapath accesses onto one fixed-latency single-port memory.
// state | meaning
// IDLE  | no transaction in flight, grant allowed
// ISSUE | mem_en strobe for the latched transaction
// WAIT  | waiting MEM_LAT cycles for read data; last cycle returns response and may grant
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 4,
    parameter int PRIO_DATA  = 1
) (
    input  logic          clk,
    input  logic          proc_rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dp_req,
    input  logic          dp_we,
    input  logic [AW-1:0] dp_addr,
    input  logic [DW-1:0] dp_wdata,
    output logic          dp_gnt,
    output logic          dp_done,
    output logic [DW-1:0] dp_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic          PRIO_DP    = (PRIO_DATA != 0);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    owner_e         owner_q, owner_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           we_q, we_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]  streak_q, streak_d;

    logic final_wait, grant_ok, any_gnt;
    logic pick_if, pick_dp;
    logic p_gnt, o_gnt, o_req;

    assign final_wait = (state_q == WAIT) && (cnt_q == '0);
    // gated by reset so no grant is reported while held in reset
    assign grant_ok   = proc_rst && ((state_q == IDLE) || final_wait);

    arb_pick u_pick (
        .req_a      (if_req & grant_ok),
        .req_b      (dp_req & grant_ok),
        .prio       (PRIO_DP),
        .streak_hit (streak_q == STREAK_MAX),
        .gnt_a      (pick_if),
        .gnt_b      (pick_dp)
    );

    assign if_gnt  = pick_if;
    assign dp_gnt  = pick_dp;
    assign any_gnt = pick_if | pick_dp;

    assign p_gnt = PRIO_DP ? pick_dp : pick_if;
    assign o_gnt = PRIO_DP ? pick_if : pick_dp;
    assign o_req = PRIO_DP ? if_req  : dp_req;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        streak_d = streak_q;

        case (state_q)
            IDLE: begin
                if (any_gnt) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = LAT_LOAD;
            end
            WAIT: begin
                if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
                else             state_d = any_gnt ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (any_gnt) begin
            owner_d = pick_dp ? OWN_DP : OWN_IF;
            addr_d  = pick_dp ? dp_addr : if_addr;
            we_d    = pick_dp & dp_we;
            wdata_d = pick_dp ? dp_wdata : '0;
        end

        if (!o_req || o_gnt) streak_d = '0;
        else if (p_gnt && (streak_q != STREAK_MAX)) streak_d = streak_q + 1'b1;
    end

    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= OWN_IF;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            streak_q <= streak_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

    assign if_rvalid = final_wait && (owner_q == OWN_IF);
    assign dp_done   = final_wait && (owner_q == OWN_DP);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dp_rdata  = dp_done   ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard and a latency-2 memory model.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        own;
        logic [15:0] data;
    } rsp_t;

    int tests = 0;
    int fails = 0;
    rsp_t sb[$];

    logic clk = 1'b0;
    logic proc_rst;
    always #5 clk = ~clk;

    // instance A: PRIO_DATA=1
    logic        if_req, if_gnt, if_rvalid;
    logic [15:0] if_addr, if_rdata;
    logic        dp_req, dp_we, dp_gnt, dp_done;
    logic [15:0] dp_addr, dp_wdata, dp_rdata;
    logic        mem_en, mem_we, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    // instance B: PRIO_DATA=0
    logic        b_if_req, b_if_gnt, b_if_rvalid;
    logic [15:0] b_if_addr, b_if_rdata;
    logic        b_dp_req, b_dp_we, b_dp_gnt, b_dp_done;
    logic [15:0] b_dp_addr, b_dp_wdata, b_dp_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.PRIO_DATA(1)) dut (
        .clk(clk), .proc_rst(proc_rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
        .dp_gnt(dp_gnt), .dp_done(dp_done), .dp_rdata(dp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.PRIO_DATA(0)) dut_f (
        .clk(clk), .proc_rst(proc_rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .dp_req(b_dp_req), .dp_we(b_dp_we), .dp_addr(b_dp_addr), .dp_wdata(b_dp_wdata),
        .dp_gnt(b_dp_gnt), .dp_done(b_dp_done), .dp_rdata(b_dp_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // memory: read data appears two cycles after mem_en, stores return 0
    logic [15:0] pa0, pa1, pb0, pb1;
    always @(posedge clk) begin
        pa0 <= (mem_en && !mem_we) ? memf(mem_addr) : 16'h0;
        pa1 <= pa0;
        pb0 <= (b_mem_en && !b_mem_we) ? memf(b_mem_addr) : 16'h0;
        pb1 <= pb0;
    end
    assign mem_rdata   = pa1;
    assign b_mem_rdata = pb1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic own, input logic [15:0] data);
        rsp_t e;
        e.own  = own;
        e.data = data;
        sb.push_back(e);
    endtask

    // returns at the negedge of the grant cycle; who: 0=if, 1=dp, -1=none in budget
    task automatic wait_gnt(input bit inst_b, input int budget, output int who);
        logic g_if, g_dp;
        who = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            g_if = inst_b ? b_if_gnt : if_gnt;
            g_dp = inst_b ? b_dp_gnt : dp_gnt;
            chk("gnt_onehot", {31'b0, g_if & g_dp}, 32'd0);
            if (g_if || g_dp) begin
                who = g_dp ? 1 : 0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // response monitor for instance A
    always @(negedge clk) begin
        rsp_t e;
        if (!if_rvalid) chk("if_rdata_idle", {16'b0, if_rdata}, 32'd0);
        if (!dp_done)   chk("dp_rdata_idle", {16'b0, dp_rdata}, 32'd0);
        if (if_rvalid || dp_done) begin
            chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_owner", {31'b0, dp_done}, {31'b0, e.own});
                chk("rsp_data", {16'b0, dp_done ? dp_rdata : if_rdata}, {16'b0, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int who;
    bit exp_a[10];
    bit exp_b[6];

    initial begin
        exp_a = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        proc_rst = 1'b0;
        if_req = 1'b1; if_addr = 16'h0;
        dp_req = 1'b0; dp_we = 1'b0; dp_addr = 16'h0; dp_wdata = 16'h0;
        b_if_req = 1'b0; b_if_addr = 16'h0;
        b_dp_req = 1'b0; b_dp_we = 1'b0; b_dp_addr = 16'h0; b_dp_wdata = 16'h0;

        // reset state, grant suppressed while in reset
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
        chk("rst_dp_done", {31'b0, dp_done}, 32'd0);
        @(posedge clk); #1;
        proc_rst = 1'b1;
        if_req = 1'b0;
        @(posedge clk); #1;

        // single fetch
        if_req = 1'b1; if_addr = 16'h0010;
        wait_gnt(0, 1, who);
        chk("fetch_gnt", who, 32'd0);
        push(1'b0, memf(16'h0010));
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch_mem_en", {31'b0, mem_en}, 32'd1);
        chk("fetch_mem_we", {31'b0, mem_we}, 32'd0);
        chk("fetch_mem_addr", {16'b0, mem_addr}, 32'h0010);
        chk("fetch_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("fetch_wait_en", {31'b0, mem_en}, 32'd0);
        @(negedge clk);
        chk("fetch_rvalid", {31'b0, if_rvalid}, 32'd1);
        chk("fetch_no_done", {31'b0, dp_done}, 32'd0);
        @(posedge clk); #1;

        // store
        dp_req = 1'b1; dp_we = 1'b1; dp_addr = 16'h0200; dp_wdata = 16'hBEEF;
        wait_gnt(0, 1, who);
        chk("store_gnt", who, 32'd1);
        push(1'b1, 16'h0000);
        @(posedge clk); #1;
        dp_req = 1'b0;
        @(negedge clk);
        chk("store_mem_en", {31'b0, mem_en}, 32'd1);
        chk("store_mem_we", {31'b0, mem_we}, 32'd1);
        chk("store_mem_addr", {16'b0, mem_addr}, 32'h0200);
        chk("store_mem_wdata", {16'b0, mem_wdata}, 32'hBEEF);
        repeat (2) @(negedge clk);
        chk("store_done", {31'b0, dp_done}, 32'd1);
        @(posedge clk); #1;
        dp_we = 1'b0;

        // reset in the middle of WAIT drops the response
        dp_req = 1'b1; dp_addr = 16'h0400;
        wait_gnt(0, 1, who);
        chk("rstw_gnt", who, 32'd1);
        @(posedge clk); #1;
        dp_req = 1'b0;
        @(posedge clk); #1;
        proc_rst = 1'b0;
        @(negedge clk);
        chk("rstw_busy", {31'b0, busy}, 32'd0);
        chk("rstw_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rstw_done", {31'b0, dp_done}, 32'd0);
        @(posedge clk); #1;
        proc_rst = 1'b1;
        @(negedge clk);
        chk("rstw_no_done", {31'b0, dp_done}, 32'd0);
        chk("rstw_idle", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;

        // back-to-back datapath loads
        dp_req = 1'b1; dp_addr = 16'h0500;
        wait_gnt(0, 1, who);
        chk("b2b_gnt1", who, 32'd1);
        push(1'b1, memf(16'h0500));
        @(posedge clk); #1;
        dp_addr = 16'h0504;
        @(negedge clk);
        chk("b2b_en1", {31'b0, mem_en}, 32'd1);
        @(negedge clk);
        chk("b2b_no_gnt", {31'b0, dp_gnt}, 32'd0);
        chk("b2b_gap_en", {31'b0, mem_en}, 32'd0);
        @(negedge clk);
        chk("b2b_gnt2", {31'b0, dp_gnt}, 32'd1);
        chk("b2b_done1", {31'b0, dp_done}, 32'd1);
        push(1'b1, memf(16'h0504));
        @(posedge clk); #1;
        dp_req = 1'b0;
        @(negedge clk);
        chk("b2b_en2", {31'b0, mem_en}, 32'd1);
        chk("b2b_addr2", {16'b0, mem_addr}, 32'h0504);
        repeat (3) @(posedge clk);
        #1;

        // contention with datapath priority and streak limit
        if_req = 1'b1; if_addr = 16'h0100;
        dp_req = 1'b1; dp_addr = 16'h0300;
        for (int g = 0; g < 10; g++) begin
            wait_gnt(0, 5, who);
            chk("cont_order", who, exp_a[g] ? 32'd1 : 32'd0);
            push(exp_a[g], memf(exp_a[g] ? dp_addr : if_addr));
            @(posedge clk); #1;
            if (who == 1)      dp_addr = dp_addr + 16'd1;
            else if (who == 0) if_addr = if_addr + 16'd1;
        end
        if_req = 1'b0; dp_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // fetch priority on the second instance
        b_if_req = 1'b1; b_if_addr = 16'h0700;
        b_dp_req = 1'b1; b_dp_addr = 16'h0800;
        for (int g = 0; g < 6; g++) begin
            wait_gnt(1, 5, who);
            chk("prio_if_order", who, exp_b[g] ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        b_if_req = 1'b0; b_dp_req = 1'b0;
        repeat (5) @(posedge clk);

        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
